// File: rtl/leak_scale_arbiter.sv
// leak_scale_arbiter: round-robin arbiter that shares one x*COEF_NUM/COEF_DEN datapath among NREQ requesters.
// Define SCALE_SAT_EN to clamp out-of-range quotients to the signed W-bit limits instead of wrapping.
module leak_scale_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 64,
    parameter int COEF_NUM = 90,
    parameter int COEF_DEN = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_data,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = 2 * W;
    localparam logic signed [PW-1:0] NUM = PW'(COEF_NUM);
    localparam logic signed [PW-1:0] DEN = PW'(COEF_DEN);

    typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         next_ptr;
    logic [IDW-1:0]         grant_idx;
    logic                   grant_found;
    logic signed [W-1:0]    operand;
    logic signed [PW-1:0]   operand_ext;
    logic signed [PW-1:0]   product;
    logic [W-1:0]           scaled;

    // Rotating priority scan: first valid index at or after rr_ptr.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        int scan;
        scan        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = (int'(rr_ptr) + k) % NREQ;
            if (!grant_found && req_valid[scan]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(scan);
            end
        end
    end

    assign req_ready = (state == IDLE && grant_found && !rst) ? (NREQ'(1) << grant_idx) : '0;

    assign next_ptr    = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
    assign operand_ext = PW'(operand);

`ifdef SCALE_SAT_EN
    localparam logic signed [PW-1:0] RMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] RMIN = ~RMAX;

    logic signed [PW-1:0] quotient;
    assign quotient = product / DEN;

    always_comb begin
        if (quotient > RMAX)
            scaled = RMAX[W-1:0];
        else if (quotient < RMIN)
            scaled = RMIN[W-1:0];
        else
            scaled = quotient[W-1:0];
    end
`else
    // Signed division truncates toward zero; only the low W bits survive.
    assign scaled = W'(product / DEN);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_found)
                    state_next = MUL;
            end
            MUL:  state_next = DIV;
            DIV:  state_next = HOLD;
            HOLD: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: datapath registers are cleared on reset too, so no stale operand or result is ever observable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            operand  <= '0;
            product  <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: if (grant_found) begin
                    operand <= req_data[grant_idx*W +: W];
                    rsp_id  <= grant_idx;
                end
                MUL:  product  <= operand_ext * NUM;
                DIV:  rsp_data <= scaled;
                HOLD: if (rsp_ready) rr_ptr <= next_ptr;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leak_scale_arbiter.sv
// Directed scoreboard bench for leak_scale_arbiter: a default 4x64 instance plus a 2x8 instance for overflow handling.
module tb_leak_scale_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 64;

    logic                clk       = 1'b0;
    logic                rst       = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*W-1:0]   req_data  = '0;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [1:0]          rsp_id;
    logic [W-1:0]        rsp_data;
    logic                busy;

    logic [1:0]          s_valid     = '0;
    logic [15:0]         s_data      = '0;
    logic [1:0]          s_ready;
    logic                s_rsp_valid;
    logic                s_rsp_ready = 1'b1;
    logic [0:0]          s_rsp_id;
    logic [7:0]          s_rsp_data;
    logic                s_busy;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef SCALE_SAT_EN
    localparam logic [7:0] S_POS = 8'h7F;  // 100*2 clamps to 127
    localparam logic [7:0] S_NEG = 8'h80;  // -100*2 clamps to -128
`else
    localparam logic [7:0] S_POS = 8'hC8;  // 200 wraps to -56
    localparam logic [7:0] S_NEG = 8'h38;  // -200 wraps to 56
`endif

    always #5 clk = ~clk;

    leak_scale_arbiter #(.NREQ(NREQ), .W(W), .COEF_NUM(90), .COEF_DEN(100)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    leak_scale_arbiter #(.NREQ(2), .W(8), .COEF_NUM(200), .COEF_DEN(100)) dut_s (
        .clk(clk), .rst(rst), .req_valid(s_valid), .req_data(s_data), .req_ready(s_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [63:0] v);
        req_data[idx*W +: W] = v;
    endtask

    // Called just after a negedge in IDLE; returns at the negedge following the accept edge (MUL).
    task automatic do_accept(input int idx, input logic [63:0] exp_data);
        #1;
        chk("req_ready_grant", 64'(req_ready), 64'(4'b0001 << idx));
        sb.push_back('{id: 2'(idx), data: exp_data});
        @(negedge clk);
        chk("req_ready_in_service", 64'(req_ready), 64'd0);
        chk("busy_in_service", 64'(busy), 64'd1);
    endtask

    // lat0 = negedges already consumed since the accept edge.
    task automatic get_rsp(input int stall, input int lat0);
        int   lat;
        exp_t e;
        lat = lat0;
        if (stall > 0) rsp_ready = 1'b0;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", 64'(lat), 64'd3);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{id: 2'bxx, data: 'x};
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_data", rsp_data, e.data);
            chk("hold_rsp_id", 64'(rsp_id), 64'(e.id));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_rsp", 64'(busy), 64'd0);
    endtask

    task automatic s_run(input int idx, input logic [7:0] v, input logic [7:0] exp);
        int lat;
        s_data[idx*8 +: 8] = v;
        s_valid = 2'(2'b01 << idx);
        #1;
        chk("s_req_ready", 64'(s_ready), 64'(2'b01 << idx));
        @(negedge clk);
        s_valid = '0;
        lat = 1;
        while (!s_rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("s_latency", 64'(lat), 64'd3);
        chk("s_rsp_data", 64'(s_rsp_data), 64'(exp));
        chk("s_rsp_id", 64'(s_rsp_id), 64'(idx));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with requests already pending
        req_valid = '1;
        s_valid   = '1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_req_ready", 64'(s_ready), 64'd0);
        s_valid = '0;

        // All four requesting 1000: round robin 0..3, each 900
        for (int i = 0; i < NREQ; i++) set_data(i, 64'd1000);
        rsp_ready = 1'b1;
        rst       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            do_accept(i, 64'd900);
            get_rsp(0, 1);
        end
        req_valid = '0;

        // Requester 2 alone with -7: truncation toward zero gives -6
        set_data(2, 64'hFFFF_FFFF_FFFF_FFF9);
        req_valid = 4'b0100;
        do_accept(2, 64'hFFFF_FFFF_FFFF_FFFA);
        req_valid = '0;
        get_rsp(0, 1);

        // Downstream stalls 5 cycles in HOLD while every requester is asserting
        set_data(0, 64'd12345);
        req_valid = 4'b0001;
        do_accept(0, 64'd11110);
        req_valid = '1;
        get_rsp(5, 1);
        req_valid = '0;

        // Largest positive and most negative operands
        set_data(1, 64'h7FFF_FFFF_FFFF_FFFF);
        req_valid = 4'b0010;
        do_accept(1, 64'h7333_3333_3333_3332);
        req_valid = '0;
        get_rsp(0, 1);
        set_data(2, 64'h8000_0000_0000_0000);
        req_valid = 4'b0100;
        do_accept(2, 64'h8CCC_CCCC_CCCC_CCCD);
        req_valid = '0;
        get_rsp(0, 1);

        // Reset during DIV drops the result and restarts round robin at 0
        set_data(3, 64'd50);
        req_valid = 4'b1000;
        #1;
        chk("pre_reset_grant", 64'(req_ready), 64'b1000);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_mid_busy", 64'(busy), 64'd0);
        chk("reset_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
        end
        set_data(0, 64'd1000);
        req_valid = '1;
        do_accept(0, 64'd900);
        get_rsp(0, 1);
        req_valid = '0;

        // Requester 1 raises then drops while 0 is in service: it loses its turn
        set_data(0, 64'd200);
        set_data(2, 64'd300);
        req_valid = 4'b0001;
        do_accept(0, 64'd180);
        req_valid = 4'b0011;
        @(negedge clk);
        chk("ignored_while_busy", 64'(req_ready), 64'd0);
        req_valid = 4'b1100;
        get_rsp(0, 2);
        do_accept(2, 64'd270);
        req_valid = '0;
        get_rsp(0, 1);

        // 8-bit instance: overflow wraps or clamps
        s_run(0, 8'd100, S_POS);
        s_run(1, 8'h9C, S_NEG);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
